// File: rtl/debug_read_sequencer_pkg.sv
// debug_read_sequencer_pkg: state/target encodings and address wrap helper
package debug_read_sequencer_pkg;
    localparam int CMD_W = 12;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, DONE} state_e;
    typedef enum logic [1:0] {REG, DMEM, IMEM, RSVD} target_e;
    // Increment modulo 2^w so each target wraps at its own address width
    function automatic logic [CMD_W-1:0] wrap_inc(input logic [CMD_W-1:0] a, input int w);
        logic [CMD_W-1:0] m;
        m = CMD_W'((1 << w) - 1);
        return (a + 1'b1) & m;
    endfunction
endpackage

// File: rtl/debug_rdata_mux.sv
// debug_rdata_mux: selects the read word of the active target, zero-extended
module debug_rdata_mux
    import debug_read_sequencer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int INST_W = 16
) (
    input  target_e             target,
    input  logic [DATA_W-1:0]   reg_rdata,
    input  logic [DATA_W-1:0]   dmem_rdata,
    input  logic [INST_W-1:0]   imem_rdata,
    output logic [INST_W-1:0]   rdata
);
    always_comb rdata = target == REG  ? INST_W'(reg_rdata) :
                        target == DMEM ? INST_W'(dmem_rdata) :
                        target == IMEM ? imem_rdata : '0;
endmodule

// File: rtl/debug_read_sequencer.sv
// debug_read_sequencer: walks a debug address range of one CPU memory and
// streams the read words out through a valid/ready port.
module debug_read_sequencer
    import debug_read_sequencer_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int INST_W         = 16,
    parameter int D_ADDR_W       = 12,
    parameter int I_ADDR_W       = 12,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int RD_LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_target,
    input  logic [CMD_W-1:0]          cmd_start_addr,
    input  logic [CMD_W-1:0]          cmd_count,
    input  logic                      abort,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INST_W-1:0]         out_data,
    output logic                      out_last,
    output logic                      done,
    output logic                      err,
    output logic                      busy,
    output logic                      debug_enable,
    output logic [REG_ADDR_WIDTH-1:0] reg_debug_addr,
    output logic [D_ADDR_W-1:0]       dmem_debug_addr,
    output logic [I_ADDR_W-1:0]       imem_debug_addr,
    input  logic [DATA_W-1:0]         reg_debug_rdata,
    input  logic [DATA_W-1:0]         dmem_debug_rdata,
    input  logic [INST_W-1:0]         imem_debug_rdata
);
    state_e            state;
    target_e           tgt;
    logic [CMD_W-1:0]  addr;
    logic [CMD_W-1:0]  remaining;
    logic [1:0]        wait_cnt;
    logic [INST_W-1:0] data_q;
    logic [INST_W-1:0] rdata;
    logic              valid_q;
    logic              last_q;
    logic              active;
    logic              rd_now;
    int                addr_w;

    debug_rdata_mux #(.DATA_W(DATA_W), .INST_W(INST_W)) u_mux (
        .target     (tgt),
        .reg_rdata  (reg_debug_rdata),
        .dmem_rdata (dmem_debug_rdata),
        .imem_rdata (imem_debug_rdata),
        .rdata      (rdata)
    );

    always_comb begin
        active = state == ISSUE || state == WAIT || state == SEND;
        rd_now = state == ISSUE ? RD_LATENCY == 0 : wait_cnt == 2'(RD_LATENCY - 1);
        addr_w = tgt == REG ? REG_ADDR_WIDTH : tgt == DMEM ? D_ADDR_W : I_ADDR_W;
    end

    // Abort must squash the word in the same cycle, so valid is gated combinationally
    assign out_valid       = valid_q && !abort;
    assign out_last        = last_q && !abort;
    assign out_data        = data_q;
    assign reg_debug_addr  = (debug_enable && tgt == REG)  ? addr[REG_ADDR_WIDTH-1:0] : '0;
    assign dmem_debug_addr = (debug_enable && tgt == DMEM) ? addr[D_ADDR_W-1:0] : '0;
    assign imem_debug_addr = (debug_enable && tgt == IMEM) ? addr[I_ADDR_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            tgt          <= REG;
            addr         <= '0;
            remaining    <= '0;
            wait_cnt     <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            debug_enable <= 1'b0;
            cmd_ready    <= 1'b0;
        end else if (active && abort) begin
            state        <= DONE;
            done         <= 1'b1;
            err          <= 1'b1;
            debug_enable <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        tgt       <= target_e'(cmd_target);
                        addr      <= cmd_start_addr;
                        remaining <= cmd_count;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_count == '0 || target_e'(cmd_target) == RSVD) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= target_e'(cmd_target) == RSVD;
                        end else begin
                            state        <= ISSUE;
                            debug_enable <= 1'b1;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    if (rd_now) begin
                        data_q  <= rdata;
                        valid_q <= 1'b1;
                        last_q  <= remaining == 12'd1;
                        state   <= SEND;
                    end else begin
                        wait_cnt <= state == ISSUE ? 2'd0 : wait_cnt + 2'd1;
                        state    <= WAIT;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        valid_q   <= 1'b0;
                        last_q    <= 1'b0;
                        addr      <= wrap_inc(addr, addr_w);
                        remaining <= remaining - 12'd1;
                        if (remaining == 12'd1) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            err          <= 1'b0;
                            debug_enable <= 1'b0;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    err       <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_read_sequencer.sv
// tb_debug_read_sequencer: scoreboard bench with memory models and a
// reference model computing expected words from target/start/count.
module tb_debug_read_sequencer;
    localparam int L = 1;

    logic        clk = 1'b0;
    logic        reset_n, cmd_valid, cmd_ready, abort, out_valid, out_ready, out_last;
    logic        done, err, busy, debug_enable;
    logic [1:0]  cmd_target;
    logic [11:0] cmd_start_addr, cmd_count;
    logic [15:0] out_data;
    logic [3:0]  reg_debug_addr;
    logic [11:0] dmem_debug_addr, imem_debug_addr;
    logic [7:0]  reg_debug_rdata, dmem_debug_rdata;
    logic [15:0] imem_debug_rdata;

    always #5 clk = ~clk;

    debug_read_sequencer #(.RD_LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_start_addr(cmd_start_addr), .cmd_count(cmd_count),
        .abort(abort), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done), .err(err), .busy(busy), .debug_enable(debug_enable),
        .reg_debug_addr(reg_debug_addr), .dmem_debug_addr(dmem_debug_addr),
        .imem_debug_addr(imem_debug_addr), .reg_debug_rdata(reg_debug_rdata),
        .dmem_debug_rdata(dmem_debug_rdata), .imem_debug_rdata(imem_debug_rdata)
    );

    logic [7:0]  regf [16];
    logic [7:0]  dmem [4096];
    logic [15:0] imem [4096];

    // One-cycle synchronous-read memories
    always @(posedge clk) begin
        reg_debug_rdata  <= regf[reg_debug_addr];
        dmem_debug_rdata <= dmem[dmem_debug_addr];
        imem_debug_rdata <= imem[imem_debug_addr];
    end

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [27:0] ports;
    } word_t;

    word_t exp_q[$];
    bit    exp_err_q[$];
    int    hs_cyc[$];
    int    checks = 0, failures = 0, hs_count = 0, done_count = 0, valid_cycles = 0, cyc = 0;
    bit    rdy_rand = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops the scoreboard whenever a word or a done pulse appears
    always @(negedge clk) begin
        if (reset_n) begin
            cyc++;
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                hs_count++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) flag("unexpected_word");
                else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(w.data));
                    check("out_last", 32'(out_last), 32'(w.last));
                    check("debug_addr", 32'({reg_debug_addr, dmem_debug_addr, imem_debug_addr}), 32'(w.ports));
                end
            end else if (out_last && !out_valid) flag("last_without_valid");
            if (done) begin
                done_count++;
                if (exp_err_q.size() == 0) flag("unexpected_done");
                else check("done_err", 32'(err), 32'(exp_err_q.pop_front()));
                check("done_debug_en", 32'(debug_enable), 32'(0));
            end
        end
    end

    // Reference model: word i of a command reads address (start+i) mod target size
    task automatic push_cmd(input int tgt, input int start, input int count, input int keep);
        int size, n, a;
        word_t w;
        size = tgt == 0 ? 16 : 4096;
        n = keep >= 0 ? keep : (tgt == 3 ? 0 : count);
        for (int i = 0; i < n; i++) begin
            a = ((start % size) + i) % size;
            w.data  = tgt == 0 ? {8'h00, regf[a]} : tgt == 1 ? {8'h00, dmem[a]} : imem[a];
            w.last  = i == count - 1;
            w.ports = {tgt == 0 ? 4'(a) : 4'd0, tgt == 1 ? 12'(a) : 12'd0, tgt == 2 ? 12'(a) : 12'd0};
            exp_q.push_back(w);
        end
        exp_err_q.push_back(tgt == 3 || keep >= 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input int tgt, input int start, input int count);
        int n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (!cmd_ready) flag("cmd_ready_timeout");
        cmd_valid = 1'b1;
        cmd_target = 2'(tgt);
        cmd_start_addr = 12'(start);
        cmd_count = 12'(count);
        tick();
        cmd_valid = 1'b0;
        cmd_target = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_count == d0 && n < 500) begin tick(); n++; end
        if (done_count == d0) flag("done_timeout");
    endtask

    task automatic run_cmd(input int tgt, input int start, input int count);
        int d0 = done_count;
        push_cmd(tgt, start, count, -1);
        issue(tgt, start, count);
        wait_done(d0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        if (!out_valid) flag("valid_timeout");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, h0, n, st;
        logic [15:0] held;
        reset_n = 0; cmd_valid = 0; cmd_target = 0; cmd_start_addr = 0; cmd_count = 0;
        abort = 0; out_ready = 0;
        for (int i = 0; i < 16; i++) regf[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) begin dmem[i] = 8'($urandom); imem[i] = 16'($urandom); end
        dmem[12'h010] = 8'hA1; dmem[12'h011] = 8'hB2; dmem[12'h012] = 8'hC3;
        repeat (3) tick();
        check("reset_ctrl", 32'({cmd_ready, out_valid, out_last, done, err, busy, debug_enable}), 0);
        check("reset_addr", 32'({reg_debug_addr, dmem_debug_addr, imem_debug_addr}), 0);
        reset_n = 1;
        tick();
        check("ready_after_reset", 32'(cmd_ready), 1);

        // dmem read of three preloaded words at full rate
        out_ready = 1;
        hs_cyc.delete();
        run_cmd(1, 12'h010, 3);
        check("s1_words", 32'(hs_cyc.size()), 3);
        if (hs_cyc.size() == 3) begin
            check("s1_gap0", 32'(hs_cyc[1] - hs_cyc[0]), L + 2);
            check("s1_gap1", 32'(hs_cyc[2] - hs_cyc[1]), L + 2);
        end

        // register address wrap 14,15,0,1
        run_cmd(0, 14, 4);

        // backpressure on imem
        out_ready = 0;
        h0 = hs_count; d0 = done_count;
        st = int'($urandom_range(0, 4095));
        push_cmd(2, st, 2, -1);
        issue(2, st, 2);
        wait_valid();
        held = out_data;
        repeat (5) begin
            tick();
            check("bp_data_stable", 32'(out_data), 32'(held));
            check("bp_dbg_en", 32'({out_valid, debug_enable}), 32'(3));
        end
        out_ready = 1;
        wait_done(d0);
        check("bp_word_count", 32'(hs_count - h0), 2);

        // abort after second handshake
        h0 = hs_count; d0 = done_count;
        push_cmd(1, 12'h100, 10, 2);
        issue(1, 12'h100, 10);
        n = 0;
        while (hs_count < h0 + 2 && n < 100) begin tick(); n++; end
        abort = 1;
        tick();
        abort = 0;
        check("abort_state", 32'({done, err, debug_enable, out_valid, busy}), 32'(5'b11001));
        wait_done(d0);
        check("abort_words", 32'(hs_count - h0), 2);

        // count zero and reserved target
        valid_cycles = 0;
        run_cmd(1, 5, 0);
        run_cmd(3, 7, 5);
        check("edge_no_valid", 32'(valid_cycles), 0);

        // reset during SEND
        out_ready = 0;
        push_cmd(1, 12'h200, 5, -1);
        issue(1, 12'h200, 5);
        wait_valid();
        reset_n = 0;
        tick();
        check("midreset_outs", 32'({out_valid, busy, done, debug_enable, cmd_ready}), 0);
        exp_q.delete();
        exp_err_q.delete();
        d0 = done_count;
        reset_n = 1;
        tick();
        check("midreset_ready", 32'(cmd_ready), 1);
        check("midreset_no_done", 32'(done_count), 32'(d0));
        out_ready = 1;
        run_cmd(1, 12'hFFE, 4);

        // randomized commands with random backpressure
        rdy_rand = 1;
        repeat (30)
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 6)));
        rdy_rand = 0;
        out_ready = 1;
        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size() + exp_err_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
